// File: rtl/mcu_datapath_pkg.sv
// mcu_datapath_pkg: ALU op codes and APSR bit positions shared by the datapath and its ALU
package mcu_datapath_pkg;
  typedef enum logic [2:0] {
    ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOTA, ALU_PASSA
  } alu_op_e;
  localparam int APSR_WIDTH = 4;
  localparam int APSR_N = 3;
  localparam int APSR_Z = 2;
  localparam int APSR_C = 1;
  localparam int APSR_V = 0;
endpackage

// File: rtl/mcu_datapath_alu.sv
// mcu_alu: combinational ALU producing the result and N/Z/C/V flags
module mcu_alu
  import mcu_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] result_o,
  output logic              n_o,
  output logic              z_o,
  output logic              c_o,
  output logic              v_o
);
  logic              sub;
  logic              arith;
  logic [DATA_W-1:0] bb;
  logic [DATA_W:0]   sum;
  // SUB reuses the adder as A + ~B + cin, so C=1 means no borrow
  always_comb begin
    sub   = op_i == ALU_SUB;
    arith = sub || op_i == ALU_ADD;
    bb    = sub ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, bb} + {{DATA_W{1'b0}}, cin_i};
    result_o = '0;
    case (op_i)
      ALU_PASSB: result_o = b_i;
      ALU_ADD,
      ALU_SUB:   result_o = sum[DATA_W-1:0];
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_NOTA:  result_o = ~a_i;
      ALU_PASSA: result_o = a_i;
      default:   result_o = '0;
    endcase
    n_o = result_o[DATA_W-1];
    z_o = result_o == '0;
    c_o = arith & sum[DATA_W];
    v_o = arith & (a_i[DATA_W-1] == bb[DATA_W-1]) & (sum[DATA_W-1] != a_i[DATA_W-1]);
  end
endmodule

// File: rtl/mcu_datapath.sv
// mcu_datapath: accumulator datapath (addr reg, RAM, ALU, ACC, APSR); MCU_DP_ADC_EN feeds apsr.C into ADD/SUB
module mcu_datapath
  import mcu_datapath_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int ALUOP_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     imem_data,
  input  logic                  imm_update,
  input  logic                  ram_write,
  input  logic [ALUOP_W-1:0]    alu_operation,
  input  logic                  acc_update,
  input  logic                  psr_update,
  output logic [APSR_WIDTH-1:0] apsr,
  output logic [DATA_W-1:0]     acc,
  output logic [ADDR_W-1:0]     addr
);
  logic [DATA_W-1:0]     mem_q [2**ADDR_W];
  logic [DATA_W-1:0]     acc_q, acc_d, rdata, result;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [APSR_WIDTH-1:0] apsr_q, apsr_d, flags;
  logic                  n, z, c, v, cin;
  alu_op_e               op;
  assign op    = alu_op_e'(alu_operation);
  assign rdata = mem_q[addr_q];
`ifdef MCU_DP_ADC_EN
  assign cin = apsr_q[APSR_C];
`else
  assign cin = op == ALU_SUB;
`endif
  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i(acc_q), .b_i(rdata), .op_i(op), .cin_i(cin),
    .result_o(result), .n_o(n), .z_o(z), .c_o(c), .v_o(v)
  );
  // next-state selection; every register holds unless its own enable is set
  always_comb begin
    flags         = '0;
    flags[APSR_N] = n;
    flags[APSR_Z] = z;
    flags[APSR_C] = c;
    flags[APSR_V] = v;
    acc_d  = acc_update ? result : acc_q;
    apsr_d = psr_update ? flags : apsr_q;
    addr_d = imm_update ? imem_data : addr_q;
  end
  // architectural registers, reset overrides all enables
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      addr_q <= '0;
      apsr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      apsr_q <= apsr_d;
    end
  end
  // RAM stores the pre-edge acc at the pre-edge addr; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && ram_write) mem_q[addr_q] <= acc_q;
  end
  assign acc  = acc_q;
  assign addr = addr_q;
  assign apsr = apsr_q;
endmodule

// File: tb/tb_mcu_datapath.sv
// tb_mcu_datapath: scoreboard bench with a behavioural model of mcu_datapath (MCU_DP_ADC_EN aware)
module tb_mcu_datapath;
`ifdef MCU_DP_ADC_EN
  localparam bit ADC = 1'b1;
`else
  localparam bit ADC = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_data = '0;
  logic       imm_update = 1'b0;
  logic       ram_write = 1'b0;
  logic [2:0] alu_operation = '0;
  logic       acc_update = 1'b0;
  logic       psr_update = 1'b0;
  logic [3:0] apsr;
  logic [7:0] acc;
  logic [7:0] addr;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  acc_m = '0, addr_m = '0;
  logic [3:0]  apsr_m = '0;
  logic [7:0]  ram_m [256];
  logic [19:0] exp_q [$];
  bit          done = 1'b0;

  mcu_datapath dut (
    .clk(clk), .rst(rst), .imem_data(imem_data), .imm_update(imm_update),
    .ram_write(ram_write), .alu_operation(alu_operation), .acc_update(acc_update),
    .psr_update(psr_update), .apsr(apsr), .acc(acc), .addr(addr)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_alu(input int a, input int b, input int op, input int cf);
    int r, sa, sb, sr, cin;
    bit c, v;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      0: r = b;
      1: begin
        cin = ADC ? cf : 0;
        r = a + b + cin;
        sr = sa + sb + cin;
        c = r > 255;
        v = sr > 127 || sr < -128;
      end
      2: begin
        cin = ADC ? cf : 1;
        r = a + (255 - b) + cin;
        sr = sa - sb - 1 + cin;
        c = r > 255;
        v = sr > 127 || sr < -128;
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 255 - a;
      default: r = a;
    endcase
    r = r % 256;
    return {r > 127, r == 0, c, v, r[7:0]};
  endfunction

  task automatic cyc(input bit r, input bit im, input int imv, input bit w, input int op,
                     input bit au, input bit pu);
    logic [11:0] f;
    @(negedge clk);
    rst = r;
    imm_update = im;
    imem_data = imv[7:0];
    ram_write = w;
    alu_operation = op[2:0];
    acc_update = au;
    psr_update = pu;
    f = ref_alu(int'(acc_m), int'(ram_m[addr_m]), op, int'(apsr_m[1]));
    if (r) begin
      acc_m = '0;
      addr_m = '0;
      apsr_m = '0;
    end else begin
      if (w) ram_m[addr_m] = acc_m;
      if (au) acc_m = f[7:0];
      if (pu) apsr_m = f[11:8];
      if (im) addr_m = imv[7:0];
    end
    exp_q.push_back({acc_m, addr_m, apsr_m});
  endtask

  task automatic set_addr(input int a); cyc(0, 1, a, 0, 7, 0, 0); endtask
  task automatic alu(input int op, input bit au, input bit pu); cyc(0, 0, 0, 0, op, au, pu); endtask
  task automatic store(); cyc(0, 0, 0, 1, 7, 0, 0); endtask

  // builds v in acc from RAM[0]=0, RAM[1]=1, scratch RAM[2]; leaves apsr.C=0
  task automatic load_const(input int v);
    set_addr(0);
    alu(0, 1, 1);
    for (int b = 7; b >= 0; b--) begin
      set_addr(2);
      store();
      alu(1, 1, 0);
      if (v[b]) begin
        set_addr(1);
        alu(1, 1, 0);
      end
    end
  endtask

  task automatic poke(input int a, input int v);
    load_const(v);
    set_addr(a);
    store();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic settle(); @(posedge clk); #1; endtask

  // monitor: every clocked cycle presents a new register state to compare
  initial begin
    logic [19:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({acc, addr, apsr} === e) n_pass++;
        else $display("FAIL scoreboard: got acc=%h addr=%h apsr=%b expected acc=%h addr=%h apsr=%b",
                      acc, addr, apsr, e[19:12], e[11:4], e[3:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ram_m[i] = '0;
    cyc(1, 0, 0, 0, 7, 0, 0);
    for (int i = 1; i <= 256; i++) cyc(0, 1, i % 256, 1, 7, 0, 0);
    alu(6, 1, 0);
    set_addr(3);
    store();
    alu(1, 0, 1);
    set_addr(0);
    alu(0, 1, 0);
    set_addr(3);
    alu(2, 1, 0);
    set_addr(1);
    store();
    // reset with every enable high: registers clear, RAM[0] keeps 0
    load_const(8'hC3);
    set_addr(3);
    alu(1, 0, 1);
    set_addr(0);
    cyc(1, 1, 8'h99, 1, 1, 1, 1);
    cyc(1, 1, 8'h99, 1, 1, 1, 1);
    settle();
    chk("rst_acc", acc, 8'h00);
    chk("rst_addr", addr, 8'h00);
    chk("rst_apsr", {4'h0, apsr}, 8'h00);
    cyc(0, 0, 0, 0, 6, 1, 0);
    alu(0, 1, 0);
    settle();
    chk("rst_ram0", acc, 8'h00);
    // load/store
    poke(8'hAE, 8'h3C);
    set_addr(8'hAE);
    alu(0, 1, 0);
    settle();
    chk("load_acc", acc, 8'h3C);
    set_addr(8'h10);
    store();
    set_addr(0);
    alu(0, 1, 0);
    set_addr(8'h10);
    alu(0, 1, 0);
    settle();
    chk("store_ram10", acc, 8'h3C);
    // ADD signed overflow
    poke(8'h50, 8'h01);
    load_const(8'h7F);
    set_addr(8'h50);
    alu(1, 1, 1);
    settle();
    chk("add_ovf_acc", acc, 8'h80);
    chk("add_ovf_apsr", {4'h0, apsr}, 8'h09);
    // SUB to zero, then borrow
    poke(8'h50, 8'h05);
    load_const(8'h05);
    set_addr(3);
    alu(1, 0, 1);
    set_addr(8'h50);
    alu(2, 1, 1);
    settle();
    chk("sub_zero_acc", acc, 8'h00);
    chk("sub_zero_apsr", {4'h0, apsr}, 8'h06);
    poke(8'h50, 8'h06);
    load_const(8'h05);
    set_addr(3);
    alu(1, 0, 1);
    set_addr(8'h50);
    alu(2, 1, 1);
    settle();
    chk("sub_borrow_acc", acc, 8'hFF);
    chk("sub_borrow_apsr", {4'h0, apsr}, 8'h08);
    // same-cycle ram_write + acc_update, then imm_update + ram_write
    poke(8'h60, 8'h01);
    load_const(8'h11);
    set_addr(8'h60);
    cyc(0, 0, 0, 1, 1, 1, 0);
    settle();
    chk("rw_au_acc", acc, 8'h12);
    alu(0, 1, 0);
    settle();
    chk("rw_au_ram", acc, 8'h11);
    load_const(8'h5A);
    set_addr(8'h61);
    cyc(0, 1, 8'h62, 1, 7, 0, 0);
    set_addr(0);
    alu(0, 1, 0);
    set_addr(8'h62);
    alu(0, 1, 0);
    settle();
    chk("im_rw_new", acc, 8'h00);
    set_addr(8'h61);
    alu(0, 1, 0);
    settle();
    chk("im_rw_old", acc, 8'h5A);
    // carry-in from apsr.C
    poke(8'h70, 8'h01);
    load_const(8'h01);
    set_addr(3);
    alu(1, 0, 1);
    set_addr(8'h70);
    alu(1, 1, 0);
    settle();
    chk("adc_acc", acc, ADC ? 8'h03 : 8'h02);
    // randomized traffic against the model
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(63) == 0, 1'($urandom), int'($urandom_range(255)), 1'($urandom),
          int'($urandom_range(7)), 1'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
